// File: rtl/hash_table_pkg.sv
// Shared types for the hash-table PTG store: bus records, PTE/PTG layout and
// the fixed sequencer state codes that the merge register also decodes.
package hash_table_pkg;

  localparam int unsigned HT_NENT = 8;
  localparam logic        INV     = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ   = 3'd1,
    ST_WAIT   = 3'd2,
    ST_MERGE  = 3'd3,
    ST_WRITE  = 3'd4,
    ST_ACK    = 3'd5,
    ST_FMERGE = 3'd6,
    ST_FWRITE = 3'd7
  } ht_state_t;

  typedef struct packed {
    logic        v;
    logic [9:0]  asid;
    logic [52:0] pte;
  } pte_t;

  typedef struct packed {
    pte_t [HT_NENT-1:0] ptge;
  } ptg_t;

  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [63:0] dat;
    logic [7:0]  tid;
  } wb_cmd_request64_t;

  typedef struct packed {
    logic        ack;
    logic [63:0] dat;
    logic [7:0]  tid;
  } wb_cmd_response64_t;

  function automatic logic [2:0] ent_of(input logic [31:0] adr);
    return adr[5:3];
  endfunction

endpackage

// File: rtl/ht_ctrl_sweep_ptr.sv
// Free-ASID sweep pointer: {group, entry} counter with terminal-count detection,
// busy/done flags and the ASID latched when a sweep is accepted.
module ht_sweep_ptr #(
  parameter int unsigned PW = 13
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_load,
  input  logic [9:0]    i_asid,
  input  logic          i_adv,
  output logic [PW-1:0] o_ptr,
  output logic          o_busy,
  output logic          o_done,
  output logic [9:0]    o_asid
);

  logic [PW-1:0] r_ptr;
  logic          r_busy;
  logic          r_done;
  logic [9:0]    r_asid;
  logic          w_last;

  assign w_last = &r_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_asid <= '0;
    end else begin
      r_done <= 1'b0;
      // A request during an active sweep is dropped, so the ASID is not reloaded.
      if (i_load && !r_busy) begin
        r_busy <= 1'b1;
        r_ptr  <= '0;
        r_asid <= i_asid;
      end else if (i_adv && r_busy) begin
        r_ptr <= r_ptr + 1'b1;
        if (w_last) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_ptr  = r_ptr;
  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_asid = r_asid;

endmodule

// File: rtl/ht_ctrl.sv
// PTG store sequencer: owns BRAM port A, arbitrates Wishbone PTE accesses
// against the background free-ASID sweep and drives the merge-register state code.
module ht_ctrl
  import hash_table_pkg::*;
#(
  parameter  int unsigned NGROUP = 1024,
  localparam int unsigned ADRW   = $clog2(NGROUP)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  wb_cmd_request64_t  req,
  output wb_cmd_response64_t resp,
  input  logic               free_req,
  input  logic [9:0]         free_asid,
  output logic               free_busy,
  output logic               free_done,
  output logic [2:0]         state,
  output logic [9:0]         asid_to_free,
  output wb_cmd_request64_t  req_o,
  output logic               ena,
  output logic               wea,
  output logic [ADRW-1:0]    addra,
  input  ptg_t               douta
);

  localparam int unsigned PW = ADRW + 3;

  ht_state_t         r_state, w_next;
  wb_cmd_request64_t r_req;
  wb_cmd_request64_t w_sw_req;
  logic              r_sweep_op;
  logic              r_last_bus;
  logic              r_stb_hold;
  logic              w_grant_bus;
  logic              w_grant_sweep;
  logic              w_bus_pend;
  logic [PW-1:0]     w_ptr;
  logic [ADRW-1:0]   w_group;

  ht_sweep_ptr #(.PW(PW)) u_sweep (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (free_req),
    .i_asid (free_asid),
    .i_adv  (r_state == ST_FWRITE),
    .o_ptr  (w_ptr),
    .o_busy (free_busy),
    .o_done (free_done),
    .o_asid (asid_to_free)
  );

  assign w_bus_pend = req.cyc & req.stb & ~r_stb_hold;

  always_comb begin
    w_next        = r_state;
    w_grant_bus   = 1'b0;
    w_grant_sweep = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        // Alternate after a bus grant so the sweep always progresses.
        if (free_busy && (r_last_bus || !w_bus_pend)) begin
          w_grant_sweep = 1'b1;
          w_next        = ST_READ;
        end else if (w_bus_pend) begin
          w_grant_bus = 1'b1;
          w_next      = ST_READ;
        end
      end
      ST_READ:   w_next = ST_WAIT;
      ST_WAIT:   w_next = r_sweep_op ? ST_FMERGE : (r_req.we ? ST_MERGE : ST_ACK);
      ST_MERGE:  w_next = ST_WRITE;
      ST_WRITE:  w_next = ST_ACK;
      ST_ACK:    w_next = ST_IDLE;
      ST_FMERGE: w_next = ST_FWRITE;
      ST_FWRITE: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_req      <= '0;
      r_sweep_op <= 1'b0;
      r_last_bus <= 1'b0;
      r_stb_hold <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_grant_bus) begin
        r_req      <= req;
        r_sweep_op <= 1'b0;
        r_last_bus <= 1'b1;
      end else if (w_grant_sweep) begin
        r_sweep_op <= 1'b1;
        r_last_bus <= 1'b0;
      end
      // A strobe still high at ack must fall before it can be granted again.
      if (r_state == ST_ACK)
        r_stb_hold <= req.stb;
      else if (!req.stb)
        r_stb_hold <= 1'b0;
    end
  end

  always_comb begin
    w_sw_req              = '0;
    w_sw_req.adr[PW+2:0]  = {w_ptr, 3'b000};
  end

  assign w_group = r_sweep_op ? w_ptr[PW-1:3] : r_req.adr[ADRW+5:6];
  assign req_o   = r_sweep_op ? w_sw_req : r_req;
  assign state   = r_state;

  always_comb begin
    ena   = 1'b0;
    wea   = 1'b0;
    addra = '0;
    resp  = '0;
    unique case (r_state)
      ST_READ: begin
        ena   = 1'b1;
        addra = w_group;
      end
      ST_WRITE, ST_FWRITE: begin
        ena   = 1'b1;
        wea   = 1'b1;
        addra = w_group;
      end
      ST_ACK: begin
        // Dropping cyc mid-op still lets the op finish but hides the ack.
        if (req.cyc) begin
          resp.ack = 1'b1;
          resp.tid = r_req.tid;
          if (!r_req.we)
            resp.dat = douta.ptge[ent_of(r_req.adr)];
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ht_ctrl.sv
// Scoreboard bench for ht_ctrl with a behavioural BRAM (2-cycle read) and merge register.
module tb_ht_ctrl;
  import hash_table_pkg::*;

  localparam int unsigned NG = 8;
  localparam int unsigned AW = 3;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  wb_cmd_request64_t  req;
  wb_cmd_response64_t resp;
  logic               free_req;
  logic [9:0]         free_asid;
  logic               free_busy, free_done;
  logic [2:0]         state;
  logic [9:0]         asid_to_free;
  wb_cmd_request64_t  req_o;
  logic               ena, wea;
  logic [AW-1:0]      addra;
  ptg_t               douta;

  ptg_t          mem [NG];
  ptg_t          rd1, ht_dina;
  int            checks = 0, errors = 0;
  int            cyc_cnt = 0, passes = 0, dones = 0, wea_cnt = 0;
  logic [AW-1:0] last_wea_addr = '0;
  logic          init_go = 1'b0, poke_go = 1'b0;
  logic [AW-1:0] poke_g;
  logic [2:0]    poke_e;
  logic [63:0]   poke_v;

  typedef struct {
    logic [63:0] dat;
    logic [7:0]  tid;
  } exp_t;
  exp_t sb[$];

  ht_ctrl #(.NGROUP(NG)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .resp         (resp),
    .free_req     (free_req),
    .free_asid    (free_asid),
    .free_busy    (free_busy),
    .free_done    (free_done),
    .state        (state),
    .asid_to_free (asid_to_free),
    .req_o        (req_o),
    .ena          (ena),
    .wea          (wea),
    .addra        (addra),
    .douta        (douta)
  );

  always #5 clk = ~clk;

  function automatic pte_t mk(input int g, input int e);
    pte_t p;
    p.v    = 1'b1;
    p.asid = (e % 2 == 0) ? 10'd7 : 10'd9;
    p.pte  = 53'(g * 256 + e * 16 + 5);
    return p;
  endfunction

  function automatic ptg_t merge(input ptg_t d, input logic [2:0] st,
                                 input wb_cmd_request64_t r, input logic [9:0] a);
    ptg_t t;
    logic [2:0] e;
    t = d;
    e = r.adr[5:3];
    if (st == 3'd3) t.ptge[e] = r.dat;
    else if (d.ptge[e].asid == a) t.ptge[e].v = INV;
    return t;
  endfunction

  always @(posedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (init_go) begin
      for (int g = 0; g < int'(NG); g++)
        for (int e = 0; e < 8; e++) mem[g].ptge[e] <= mk(g, e);
    end else if (poke_go) begin
      mem[poke_g].ptge[poke_e] <= poke_v;
    end else if (ena && wea) begin
      mem[addra] <= ht_dina;
    end
    if (ena) rd1 <= mem[addra];
    douta <= rd1;
    if (state == 3'd3 || state == 3'd6) ht_dina <= merge(douta, state, req_o, asid_to_free);
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (state == 3'd7) passes <= passes + 1;
      if (free_done) dones <= dones + 1;
      if (wea) begin
        wea_cnt       <= wea_cnt + 1;
        last_wea_addr <= addra;
      end
    end
  end

  task automatic init_mem();
    init_go = 1'b1;
    @(posedge clk); #1;
    init_go = 1'b0;
  endtask

  task automatic poke(input int g, input int e, input logic [63:0] v);
    poke_g = AW'(g); poke_e = 3'(e); poke_v = v; poke_go = 1'b1;
    @(posedge clk); #1;
    poke_go = 1'b0;
  endtask

  task automatic pulse_free(input logic [9:0] a);
    free_asid = a; free_req = 1'b1;
    @(posedge clk); #1;
    free_req = 1'b0;
  endtask

  task automatic wait_sweep_end();
    for (int i = 0; i < 3000; i++) begin
      if (!free_busy) break;
      @(posedge clk); #1;
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Drives one bus op starting now (#1 after an edge); ends #1 after the edge following ack.
  task automatic do_bus(input logic we, input logic [31:0] adr, input logic [63:0] dat,
                        input logic [7:0] tid, output bit got, output int lat,
                        output logic [63:0] rdat, output logic [7:0] rtid);
    int t0;
    got = 1'b0; lat = 0; rdat = '0; rtid = '0;
    req.cyc = 1'b1; req.stb = 1'b1; req.we = we; req.adr = adr; req.dat = dat; req.tid = tid;
    t0 = cyc_cnt;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (resp.ack) begin
        got = 1'b1; lat = cyc_cnt - t0; rdat = resp.dat; rtid = resp.tid;
        break;
      end
    end
    req.cyc = 1'b0; req.stb = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({ena, wea, addra} !== '0) begin errors++; $display("FAIL reset_port_a: got %b exp 0", {ena, wea, addra}); end
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d exp 0", state); end
    checks++; if ({resp, req_o} !== '0) begin errors++; $display("FAIL reset_bus: got %h exp 0", {resp, req_o}); end
    checks++; if ({free_busy, free_done, asid_to_free} !== '0) begin errors++; $display("FAIL reset_sweep: got %h exp 0", {free_busy, free_done, asid_to_free}); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_release_state: got %0d exp 0", state); end
  endtask

  task automatic test_read();
    bit got; int lat; logic [63:0] rd; logic [7:0] rt; exp_t ex; int w0;
    init_mem();
    poke(5, 2, 64'hA5A5);
    w0 = wea_cnt;
    sb.push_back('{64'hA5A5, 8'h3C});
    do_bus(1'b0, 32'h152, 64'h0, 8'h3C, got, lat, rd, rt);
    ex = sb.pop_front();
    checks++; if (got !== 1'b1 || lat + 1 != 4) begin errors++; $display("FAIL read_latency: got ack=%0b cycle %0d exp cycle 4", got, lat + 1); end
    checks++; if (rd !== ex.dat) begin errors++; $display("FAIL read_dat: got %h exp %h", rd, ex.dat); end
    checks++; if (rt !== ex.tid) begin errors++; $display("FAIL read_tid: got %h exp %h", rt, ex.tid); end
    checks++; if (wea_cnt != w0) begin errors++; $display("FAIL read_no_wea: got %0d writes exp 0", wea_cnt - w0); end
    sb.push_back('{64'hA5A5, 8'h3D});
    do_bus(1'b0, 32'h352, 64'h0, 8'h3D, got, lat, rd, rt);
    ex = sb.pop_front();
    checks++; if (got !== 1'b1 || rd !== ex.dat) begin errors++; $display("FAIL read_wrap: got ack=%0b dat %h exp %h", got, rd, ex.dat); end
  endtask

  task automatic test_write();
    bit got; int lat; logic [63:0] rd; logic [7:0] rt; exp_t ex; int w0; int bad;
    w0 = wea_cnt;
    sb.push_back('{64'h0, 8'h22});
    do_bus(1'b1, 32'h158, 64'h1234, 8'h22, got, lat, rd, rt);
    ex = sb.pop_front();
    checks++; if (got !== 1'b1 || lat + 1 != 6) begin errors++; $display("FAIL write_latency: got ack=%0b cycle %0d exp cycle 6", got, lat + 1); end
    checks++; if (rt !== ex.tid || rd !== ex.dat) begin errors++; $display("FAIL write_resp: got tid %h dat %h exp tid %h dat %h", rt, rd, ex.tid, ex.dat); end
    checks++; if (wea_cnt - w0 != 1 || last_wea_addr !== 3'd5) begin errors++; $display("FAIL write_wea: got %0d writes at %0d exp 1 at 5", wea_cnt - w0, last_wea_addr); end
    bad = 0;
    for (int e = 0; e < 8; e++) begin
      if (e == 3) begin if (mem[5].ptge[e] !== 64'h1234) bad++; end
      else if (e == 2) begin if (mem[5].ptge[e] !== 64'hA5A5) bad++; end
      else if (mem[5].ptge[e] !== mk(5, e)) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL write_ptg: got %0d wrong entries exp 0", bad); end
    sb.push_back('{64'h1234, 8'h23});
    do_bus(1'b0, 32'h158, 64'h0, 8'h23, got, lat, rd, rt);
    ex = sb.pop_front();
    checks++; if (got !== 1'b1 || rd !== ex.dat) begin errors++; $display("FAIL write_readback: got %h exp %h", rd, ex.dat); end
  endtask

  task automatic test_sweep();
    int p0, d0, bad; pte_t ex;
    init_mem();
    p0 = passes; d0 = dones;
    pulse_free(10'd7);
    checks++; if (free_busy !== 1'b1 || asid_to_free !== 10'd7) begin errors++; $display("FAIL sweep_start: got busy %0b asid %0d exp 1 7", free_busy, asid_to_free); end
    wait_sweep_end();
    checks++; if (free_busy !== 1'b0) begin errors++; $display("FAIL sweep_timeout: got busy %0b exp 0", free_busy); end
    checks++; if (passes - p0 != int'(NG) * 8) begin errors++; $display("FAIL sweep_passes: got %0d exp %0d", passes - p0, NG * 8); end
    checks++; if (dones - d0 != 1) begin errors++; $display("FAIL sweep_done: got %0d pulses exp 1", dones - d0); end
    bad = 0;
    for (int g = 0; g < int'(NG); g++)
      for (int e = 0; e < 8; e++) begin
        ex = mk(g, e);
        if (ex.asid == 10'd7) ex.v = INV;
        if (mem[g].ptge[e] !== ex) bad++;
      end
    checks++; if (bad != 0) begin errors++; $display("FAIL sweep_mem: got %0d wrong entries exp 0", bad); end
  endtask

  task automatic test_contention();
    bit got; int lat; logic [63:0] rd; logic [7:0] rt; exp_t ex;
    int p_prev, d0, n, stbs, acks, g, e;
    init_mem();
    d0 = dones; stbs = 0; acks = 0; n = 0;
    pulse_free(10'd5);
    p_prev = passes;
    while (free_busy && n < 120) begin
      g = $urandom_range(0, NG - 1); e = $urandom_range(0, 7);
      sb.push_back('{64'(mk(g, e)), 8'(n)});
      stbs++;
      do_bus(1'b0, {23'b0, 3'(g), 3'(e), 3'b0}, 64'h0, 8'(n), got, lat, rd, rt);
      ex = sb.pop_front();
      if (got) acks++;
      checks++; if (rd !== ex.dat || rt !== ex.tid) begin errors++; $display("FAIL cont_data[%0d]: got %h/%h exp %h/%h", n, rd, rt, ex.dat, ex.tid); end
      if (n > 0) begin
        checks++; if (passes - p_prev != 1) begin errors++; $display("FAIL cont_alternate[%0d]: got %0d passes exp 1", n, passes - p_prev); end
      end
      p_prev = passes;
      n++;
    end
    wait_sweep_end();
    checks++; if (acks != stbs) begin errors++; $display("FAIL cont_acks: got %0d exp %0d", acks, stbs); end
    checks++; if (dones - d0 != 1 || free_busy !== 1'b0) begin errors++; $display("FAIL cont_sweep_done: got %0d busy %0b exp 1 0", dones - d0, free_busy); end
  endtask

  task automatic test_simultaneous();
    bit got; int lat; logic [63:0] rd; logic [7:0] rt; exp_t ex; int p0, bad; pte_t pe;
    init_mem();
    p0 = passes;
    sb.push_back('{64'(mk(2, 1)), 8'h44});
    free_asid = 10'd7; free_req = 1'b1;
    fork
      do_bus(1'b0, 32'h88, 64'h0, 8'h44, got, lat, rd, rt);
      begin @(posedge clk); #1; free_req = 1'b0; end
    join
    ex = sb.pop_front();
    checks++; if (got !== 1'b1 || lat + 1 != 4 || passes != p0) begin errors++; $display("FAIL simul_bus_first: got ack=%0b cycle %0d passes %0d exp 1 4 0", got, lat + 1, passes - p0); end
    checks++; if (rd !== ex.dat) begin errors++; $display("FAIL simul_dat: got %h exp %h", rd, ex.dat); end
    checks++; if (free_busy !== 1'b1) begin errors++; $display("FAIL simul_busy: got %0b exp 1", free_busy); end
    repeat (20) @(posedge clk);
    #1;
    pulse_free(10'd3);
    checks++; if (asid_to_free !== 10'd7) begin errors++; $display("FAIL simul_reload: got %0d exp 7", asid_to_free); end
    wait_sweep_end();
    bad = 0;
    for (int g = 0; g < int'(NG); g++)
      for (int e = 0; e < 8; e++) begin
        pe = mk(g, e);
        if (pe.asid == 10'd7) pe.v = INV;
        if (mem[g].ptge[e] !== pe) bad++;
      end
    checks++; if (bad != 0 || asid_to_free !== 10'd7) begin errors++; $display("FAIL simul_mem: got %0d wrong asid %0d exp 0 7", bad, asid_to_free); end
  endtask

  task automatic test_reset_write();
    bit seen;
    init_mem();
    seen = 1'b0;
    free_asid = 10'd9; free_req = 1'b1;
    req.cyc = 1'b1; req.stb = 1'b1; req.we = 1'b1; req.adr = 32'h1C0; req.dat = 64'hDEAD; req.tid = 8'h05;
    @(posedge clk); #1;
    free_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (state == 3'd4) begin seen = 1'b1; break; end
      @(posedge clk); #1;
    end
    checks++; if (!seen || wea !== 1'b1) begin errors++; $display("FAIL rst_reach_write: got seen %0b wea %0b exp 1 1", seen, wea); end
    rst_n = 1'b0;
    #1;
    checks++; if (wea !== 1'b0 || ena !== 1'b0) begin errors++; $display("FAIL rst_wea_async: got wea %0b ena %0b exp 0 0", wea, ena); end
    checks++; if ({state, addra, resp, req_o} !== '0) begin errors++; $display("FAIL rst_outputs: got %h exp 0", {state, addra, resp, req_o}); end
    checks++; if ({free_busy, free_done, asid_to_free} !== '0) begin errors++; $display("FAIL rst_sweep_outputs: got %h exp 0", {free_busy, free_done, asid_to_free}); end
    req = '0;
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (state !== 3'd0 || free_busy !== 1'b0) begin errors++; $display("FAIL rst_release: got state %0d busy %0b exp 0 0", state, free_busy); end
    checks++; if (mem[7].ptge[0] !== mk(7, 0)) begin errors++; $display("FAIL rst_write_aborted: got %h exp %h", mem[7].ptge[0], mk(7, 0)); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    req = '0; free_req = 1'b0; free_asid = '0;
    test_reset();
    test_read();
    test_write();
    test_sweep();
    test_contention();
    test_simultaneous();
    test_reset_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
